// File: rtl/wavetable_loader_if.sv
// Sample stream and RAM port-B signals of the waveform table writer.
interface wavetable_loader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;

    // master drives samples and observes the RAM port; slave is the loader
    modport master (
        output s_valid, s_data,
        input  s_ready, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  s_valid, s_data,
        output s_ready, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/wavetable_loader.sv
// Streams 16-bit samples into port B of the waveform RAM, one word per clock,
// with abort support and a running checksum of the words written.
module wavetable_loader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    wavetable_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_ptr;
    logic [ADDR_W:0]   remaining;
    logic              accept;
    logic              last;

    // abort wins over a handshake on the same edge
    assign accept      = (state == LOAD) && bus.s_valid && !abort;
    assign last        = (remaining == {{ADDR_W{1'b0}}, 1'b1});
    assign bus.s_ready = (state == LOAD);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start && (length != '0)) state_nx = LOAD;
            LOAD: begin
                if (abort)                state_nx = IDLE;
                else if (accept && last)  state_nx = FLUSH;
            end
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_ptr     <= '0;
            remaining    <= '0;
            checksum     <= '0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            bus.ram_we <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            busy       <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_ptr  <= base_addr;
                        remaining <= length;
                        checksum  <= '0;
                        // an empty job completes without ever leaving IDLE
                        if (length == '0) done <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (accept) begin
                        bus.ram_we   <= 1'b1;
                        bus.ram_addr <= addr_ptr;
                        bus.ram_din  <= bus.s_data;
                        addr_ptr     <= addr_ptr + 1'b1;
                        remaining    <= remaining - 1'b1;
                        checksum     <= checksum + bus.s_data;
                    end
                end
                FLUSH: begin
                    if (abort) aborted <= 1'b1;
                    else       done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wavetable_loader.sv
// Directed bench for wavetable_loader: writes, wrap, gaps, abort, empty job, reset.
module tb_wavetable_loader;
    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [15:0] base_addr;
    logic [16:0] length;
    logic        busy, done, aborted;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          hs_cyc[$];
    int          done_cyc[$];
    int          ab_cnt;
    logic [15:0] exp_q[$];

    wavetable_loader_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    wavetable_loader #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .bus(bus),
        .busy(busy), .done(done), .aborted(aborted), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // inputs settle 1ns after posedge, so the negedge sees what the next edge will
    always @(negedge clk) begin
        if (bus.ram_we) begin
            wr_addr.push_back(bus.ram_addr);
            wr_data.push_back(bus.ram_din);
            wr_cyc.push_back(cyc);
        end
        if (rst_n && bus.s_valid && bus.s_ready && !abort) hs_cyc.push_back(cyc);
        if (done)    done_cyc.push_back(cyc);
        if (aborted) ab_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        hs_cyc.delete(); done_cyc.delete(); exp_q.delete();
        ab_cnt = 0;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [16:0] l);
        start = 1'b1; base_addr = b; length = l;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic v, input logic [15:0] d);
        bus.s_valid = v; bus.s_data = d;
        step();
    endtask

    task automatic idle(input int n);
        bus.s_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic check_writes(input string tag, input logic [15:0] base, input int n);
        logic [15:0] a;
        chk({tag, "_nwr"}, wr_addr.size(), n);
        chk({tag, "_nhs"}, hs_cyc.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            a = base + 16'(i);
            chk({tag, "_addr"}, wr_addr[i], a);
            chk({tag, "_data"}, wr_data[i], exp_q[i]);
            if (i < hs_cyc.size()) chk({tag, "_lat"}, wr_cyc[i], hs_cyc[i] + 1);
        end
        chk({tag, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0 && wr_cyc.size() > 0)
            chk({tag, "_done_lat"}, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
        chk({tag, "_nabort"}, ab_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; length = '0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        #3 rst_n = 1'b0;
        repeat (2) step();
        chk("rst_ready",  bus.s_ready, 0);
        chk("rst_we",     bus.ram_we, 0);
        chk("rst_addr",   bus.ram_addr, 0);
        chk("rst_din",    bus.ram_din, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_abt",    aborted, 0);
        chk("rst_csum",   checksum, 0);
        rst_n = 1'b1;
        step();

        // back-to-back, valid held past the end: only 4 accepted
        clr();
        pulse_start(16'h0000, 17'd4);
        chk("t1_busy", busy, 1);
        chk("t1_ready", bus.s_ready, 1);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back(16'(i));
            send(1'b1, (i <= 4) ? 16'(i) : 16'hDEAD);
        end
        idle(3);
        check_writes("t1", 16'h0000, 4);
        for (int i = 1; i < wr_cyc.size(); i++) chk("t1_b2b", wr_cyc[i], wr_cyc[i-1] + 1);
        chk("t1_csum", checksum, 16'h000A);
        chk("t1_idle_busy", busy, 0);

        // address wrap and checksum wrap
        clr();
        pulse_start(16'hFFFE, 17'd4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'hA000 + 16'(i));
            send(1'b1, 16'hA000 + 16'(i));
        end
        idle(3);
        check_writes("t2", 16'hFFFE, 4);
        chk("t2_csum", checksum, 16'h8006);

        // gaps in the stream: write regs hold between handshakes
        clr();
        pulse_start(16'h0100, 17'd3);
        exp_q.push_back(16'h0011); exp_q.push_back(16'h0022); exp_q.push_back(16'h0033);
        send(1'b1, 16'h0011);
        chk("t3_we1", bus.ram_we, 1);
        chk("t3_addr1", bus.ram_addr, 16'h0100);
        send(1'b0, 16'hBAD0);
        chk("t3_we_gap", bus.ram_we, 0);
        chk("t3_addr_hold", bus.ram_addr, 16'h0100);
        chk("t3_din_hold", bus.ram_din, 16'h0011);
        send(1'b1, 16'h0022);
        send(1'b0, 16'hBAD1);
        send(1'b1, 16'h0033);
        idle(3);
        check_writes("t3", 16'h0100, 3);
        chk("t3_csum", checksum, 16'h0066);

        // abort together with the third sample
        clr();
        pulse_start(16'h0200, 17'd8);
        send(1'b1, 16'h0001);
        send(1'b1, 16'h0002);
        abort = 1'b1;
        send(1'b1, 16'h0003);
        abort = 1'b0;
        chk("t4_aborted", aborted, 1);
        chk("t4_done", done, 0);
        chk("t4_ready", bus.s_ready, 0);
        chk("t4_busy", busy, 0);
        idle(3);
        chk("t4_nwr", wr_addr.size(), 2);
        chk("t4_ndone", done_cyc.size(), 0);
        chk("t4_nabort", ab_cnt, 1);
        chk("t4_csum", checksum, 16'h0003);
        clr();
        pulse_start(16'h0300, 17'd1);
        exp_q.push_back(16'h5555);
        send(1'b1, 16'h5555);
        idle(3);
        check_writes("t4b", 16'h0300, 1);
        chk("t4b_csum", checksum, 16'h5555);

        // empty job, then start ignored while busy
        clr();
        pulse_start(16'h0000, 17'd0);
        chk("t5_done0", done, 1);
        chk("t5_busy0", busy, 0);
        chk("t5_csum0", checksum, 0);
        step();
        chk("t5_done_pulse", done, 0);
        chk("t5_nwr0", wr_addr.size(), 0);
        clr();
        pulse_start(16'h0400, 17'd2);
        exp_q.push_back(16'h0007); exp_q.push_back(16'h0008);
        start = 1'b1; base_addr = 16'h0500; length = 17'd5;
        send(1'b1, 16'h0007);
        start = 1'b0;
        send(1'b1, 16'h0008);
        idle(6);
        check_writes("t5", 16'h0400, 2);
        chk("t5_busy_after", busy, 0);
        chk("t5_csum", checksum, 16'h000F);

        // asynchronous reset mid-job
        clr();
        pulse_start(16'h0600, 17'd6);
        send(1'b1, 16'h0101);
        send(1'b1, 16'h0202);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we",    bus.ram_we, 0);
        chk("t6_addr",  bus.ram_addr, 0);
        chk("t6_din",   bus.ram_din, 0);
        chk("t6_ready", bus.s_ready, 0);
        chk("t6_busy",  busy, 0);
        chk("t6_csum",  checksum, 0);
        chk("t6_done",  done, 0);
        bus.s_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        clr();
        pulse_start(16'h0700, 17'd1);
        exp_q.push_back(16'h1234);
        send(1'b1, 16'h1234);
        idle(3);
        check_writes("t6b", 16'h0700, 1);
        chk("t6b_csum", checksum, 16'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wavetable_loader.md
Name: wavetable_loader

Overview:
- Writer side of the waveform table: accepts a stream of 16-bit samples and writes them into one port of the dual-port waveform RAM that the sine/cosine wave generators read.
- Lets software or a UART front-end reload the table (arbitrary waveform, amplitude-scaled sine) at runtime without resynthesis.
- Sits between the sample source (valid/ready stream) and RAM port B; the generators stay on port A.

Parameters:
- ADDR_W, 16, RAM address width; the table holds 2^ADDR_W words.
- DATA_W, 16, sample and RAM word width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; begins a load job when idle
- abort  input  1  ends an active job on the next edge
- base_addr  input  ADDR_W  first RAM address written; sampled on start
- length  input  ADDR_W+1  number of words to write; sampled on start; maximum 2^ADDR_W
- s_valid  input  1  sample stream valid
- s_data  input  DATA_W  sample stream data
- s_ready  output  1  sample stream ready
- ram_we  output  1  RAM port-B write enable
- ram_addr  output  ADDR_W  RAM port-B address
- ram_din  output  DATA_W  RAM port-B write data
- busy  output  1  high while in LOAD
- done  output  1  one-cycle pulse when a job completes normally
- aborted  output  1  one-cycle pulse when a job ends by abort
- checksum  output  DATA_W  modulo-2^DATA_W sum of the words written in the current/last job

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE.
  - s_ready, ram_we, busy, done, aborted = 0.
  - ram_addr=0, ram_din=0, checksum=0.
  - Internal address and remaining count = 0.
  - Asserting rst_n low mid-job drops the job at once; any write not yet issued is lost.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - s_ready=0.
  - On start=1: latch base_addr into addr_ptr and length into remaining, and clear checksum.
  - If length==0, stay in IDLE and pulse done on the next cycle.
  - Otherwise go to LOAD.
  - start while busy is ignored.
- LOAD:
  - busy=1, s_ready=1 (combinational from state).
  - Each edge with s_valid & s_ready:
    - Register ram_we=1, ram_addr=addr_ptr, ram_din=s_data.
    - addr_ptr+1, wrapping modulo 2^ADDR_W, so 0xFFFF is followed by 0x0000.
    - remaining-1.
    - checksum += s_data, wrapping.
  - When the accepted sample is the last one (remaining==1): go to FLUSH. s_ready drops in the following cycle, so exactly length samples are accepted.
  - Cycles without a handshake: ram_we=0; ram_addr and ram_din hold their values.
- FLUSH:
  - The final write is on the RAM port in this cycle.
  - Next edge: ram_we=0, done=1 for one cycle, state to IDLE, busy=0.
- Latency: sample accepted at edge N appears as a RAM write (ram_we high) during cycle N+1. done is asserted in the cycle after the last write.
- Abort:
  - abort=1 in LOAD or FLUSH has priority over a handshake on the same edge; that sample is not accepted.
  - Writes already registered still complete.
  - Next state is IDLE, aborted pulses for one cycle, done is not pulsed.
  - abort in IDLE is ignored.
- Throughput: one sample per clock sustained.
- checksum is held after the job ends until the next start.
- Outputs are glitch-free registers, except s_ready.

Test Plan:
- Reset then start, base_addr=0x0000, length=4, samples 0x0001,0x0002,0x0003,0x0004 back-to-back -> writes (0x0000,0x0001)..(0x0003,0x0004) on consecutive cycles, each one cycle after its accept; done pulses one cycle after the last write; checksum=0x000A; exactly 4 handshakes.
- base_addr=0xFFFE, length=4, samples 0xA000,0xA001,0xA002,0xA003 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001; checksum=0x8006 (wrapped).
- length=3 with s_valid toggling 1,0,1,0,1 -> ram_we high only in the cycles following the valid handshakes; ram_addr holds between writes; done after the third write.
- length=8, abort asserted together with s_valid on the 3rd sample -> only 2 writes; aborted pulses; done stays 0; s_ready=0 afterward; a new start is accepted.
- start with length=0 -> no writes, busy stays 0, done pulses one cycle later; start while busy with length=5 during a length=2 job -> ignored, only 2 writes.
- rst_n driven low mid-job after 2 of 6 samples -> all outputs reach their reset values immediately, asynchronously; after release, a fresh length=1 job completes normally.
